bg_check: RTL and testbench
===========================

# bg_check

Background read-back checker for the 256x4 SRAM BIST path. After a background fill, it sweeps every address once, ascending or descending. Each read word is compared against the expected solid background, 0000 or 1111. The block reports pass/fail, the first failing address and data, and a total error count. It drives the SRAM read port and the BIST controller's completion/fail inputs.

## Interface
- ADDR_W, 8, address width; depth = 2^ADDR_W
- DATA_W, 4, data word width
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en_in  input  1  start request; sampled only in IDLE
- rev_in  input  1  expected background select, sampled at start: 0 → all-0s, 1 → all-1s
- dir_in  input  1  sweep order, sampled at start: 0 ascending (0→max), 1 descending (max→0)
- dat_in  input  DATA_W  SRAM read data for the address presented in the previous cycle
- addr_out  output  ADDR_W  SRAM read address (registered)
- r_en_out  output  1  SRAM read enable (registered)
- busy  output  1  high in READ and DONE
- chk_done  output  1  one-cycle pulse when the sweep completes
- fail  output  1  sticky: at least one mismatch in the current/last sweep
- fail_addr  output  ADDR_W  address of the first mismatch in sweep order
- fail_data  output  DATA_W  data read at fail_addr
- err_cnt  output  ADDR_W+1  number of mismatching words (0..2^ADDR_W, no wrap)

## Operation
- Reset values: state IDLE; addr_out 0; r_en_out 0; busy 0; chk_done 0; fail 0; fail_addr 0; fail_data 0; err_cnt 0.
- State machine has three states: IDLE, READ, DONE.
- IDLE, en_in=1:
  - Latch exp = {DATA_W{rev_in}} and dir = dir_in.
  - Clear fail, fail_addr, fail_data and err_cnt.
  - Load addr_out with 0 (dir=0) or 2^ADDR_W−1 (dir=1). Set r_en_out=1. Go to READ.
- IDLE, en_in=0: outputs hold. Results from the last sweep remain readable.
- READ, every edge:
  - Compare dat_in against exp for the address currently on addr_out.
  - On mismatch: increment err_cnt. If fail was 0, latch fail_addr=addr_out and fail_data=dat_in, and set fail=1.
  - Not the final address: step addr_out by +1 (dir=0) or −1 (dir=1) and keep r_en_out=1.
  - Final address (max when ascending, 0 when descending): set r_en_out=0, addr_out=0, chk_done=1 and go to DONE.
- DONE: lasts exactly one cycle. chk_done returns to 0 and the block returns to IDLE. en_in is ignored in DONE.
- en_in is ignored in READ and DONE. A sweep is never restarted or extended.
- Address arithmetic is unsigned ADDR_W bits. The terminal-address test stops the sweep, so addr_out never wraps during a sweep.
- err_cnt is ADDR_W+1 bits wide and cannot overflow, since at most 2^ADDR_W mismatches can occur.
- Reset mid-sweep: the next edge forces every output to its reset value and the state to IDLE. Partial results are discarded.
- rst and en_in asserted on the same edge: reset wins and no sweep starts.

## Timing
- E0 is the edge sampling en_in=1 in IDLE. From E0+: r_en_out=1, busy=1, addr_out=first address.
- SRAM read latency is one cycle. dat_in must be valid for addr_out before the next rising edge.
- The k-th address (k=0..255) is on addr_out during the cycle after E(k).
- The k-th address is compared at E(k+1).
- Last compare at E256. After E256: chk_done=1, r_en_out=0, and fail, fail_addr, fail_data and err_cnt are final.
- After E257: chk_done=0, busy=0, state IDLE. The earliest next start is sampled at E258.
- Start-to-done latency is 256 cycles. The full occupancy is 257 cycles (READ + DONE).

## Test plan
- Clean ascending all-0s: SRAM model holds 0000 everywhere; rev_in=0, dir_in=0.
  - Expect addresses 0..255 in order, chk_done after E256, fail=0, err_cnt=0.
- Single fault: addr 0x5A holds 0100, all others 0000; rev_in=0.
  - Expect fail=1, fail_addr=0x5A, fail_data=0x4, err_cnt=1.
- Descending with two faults: rev_in=1, dir_in=1; addr 0x10=1110 and addr 0xF0=0111.
  - Expect addresses 255..0 in order.
  - Expect fail_addr=0xF0, fail_data=0x7 (first in sweep order), err_cnt=2.
- All-fail saturation bound: rev_in=1 against an all-0000 array.
  - Expect err_cnt=0x100, fail_addr=0x00, fail_data=0x0.
- en_in pulsed at E50, and again in the DONE cycle.
  - Expect no restart, an unchanged address sequence, and exactly one chk_done pulse.
- rst asserted at E100 mid-sweep.
  - After E100: all outputs at reset values, state IDLE.
  - A new start at E102 gives a full clean 256-address sweep with fresh results.

Source files
------------

// File: rtl/bg_check.sv
// Background read-back checker: sweeps a 2^ADDR_W x DATA_W SRAM once after a
// solid fill and reports first-failure address/data plus a total error count.
module bg_check #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              rev_in,
  input  logic              dir_in,
  input  logic [DATA_W-1:0] dat_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              r_en_out,
  output logic              busy,
  output logic              chk_done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W:0]   err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ren_q, ren_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              dir_q, dir_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic mismatch;
  logic lastAddr;

  assign mismatch = (dat_in != exp_q);
  // Terminal address depends on sweep direction; it also prevents wrap.
  assign lastAddr = dir_q ? (addr_q == '0) : (addr_q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ren_q   <= 1'b0;
      exp_q   <= '0;
      dir_q   <= 1'b0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      exp_q   <= exp_d;
      dir_q   <= dir_d;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ren_d   = ren_q;
    exp_d   = exp_q;
    dir_d   = dir_q;
    fail_d  = fail_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (en_in) begin
          exp_d   = {DATA_W{rev_in}};
          dir_d   = dir_in;
          fail_d  = 1'b0;
          faddr_d = '0;
          fdata_d = '0;
          cnt_d   = '0;
          addr_d  = dir_in ? '1 : '0;
          ren_d   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        // dat_in belongs to the address currently presented on addr_out.
        if (mismatch) begin
          cnt_d = cnt_q + 1'b1;
          if (!fail_q) begin
            fail_d  = 1'b1;
            faddr_d = addr_q;
            fdata_d = dat_in;
          end
        end
        if (lastAddr) begin
          ren_d   = 1'b0;
          addr_d  = '0;
          state_d = DONE;
        end else begin
          addr_d = dir_q ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign addr_out  = addr_q;
  assign r_en_out  = ren_q;
  assign busy      = (state_q != IDLE);
  assign chk_done  = (state_q == DONE);
  assign fail      = fail_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_bg_check.sv
// Randomized and directed bench for bg_check; a sweep-level reference model
// predicts the address sequence and the pass/fail results from the SRAM image.
module tb_bg_check;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              en_in;
  logic              rev_in;
  logic              dir_in;
  logic [DATA_W-1:0] dat_in;
  logic [ADDR_W-1:0] addr_out;
  logic              r_en_out;
  logic              busy;
  logic              chk_done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [ADDR_W:0]   err_cnt;

  logic [DATA_W-1:0] mem [DEPTH];
  int testsRun;
  int testsFailed;

  bg_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .rev_in    (rev_in),
    .dir_in    (dir_in),
    .dat_in    (dat_in),
    .addr_out  (addr_out),
    .r_en_out  (r_en_out),
    .busy      (busy),
    .chk_done  (chk_done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .err_cnt   (err_cnt)
  );

  // SRAM answers within the same cycle the registered address is presented.
  assign dat_in = mem[addr_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".addr_out"}, 32'(addr_out), 32'h0);
    checkOutput({tag, ".r_en_out"}, 32'(r_en_out), 32'h0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'h0);
    checkOutput({tag, ".chk_done"}, 32'(chk_done), 32'h0);
    checkOutput({tag, ".fail"}, 32'(fail), 32'h0);
    checkOutput({tag, ".fail_addr"}, 32'(fail_addr), 32'h0);
    checkOutput({tag, ".fail_data"}, 32'(fail_data), 32'h0);
    checkOutput({tag, ".err_cnt"}, 32'(err_cnt), 32'h0);
  endtask

  task automatic fillMem(input logic [DATA_W-1:0] bg, input int nFaults);
    logic [DATA_W-1:0] flip;
    int a;
    for (int i = 0; i < DEPTH; i++) mem[i] = bg;
    for (int i = 0; i < nFaults; i++) begin
      a    = $urandom_range(0, DEPTH - 1);
      flip = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
      mem[a] = bg ^ flip;
    end
  endtask

  // One complete sweep: the model derives the visiting order and the
  // expected results straight from the SRAM image before the sweep runs.
  task automatic applyStimulus(input logic rev, input logic dir, input int enPulseAt,
                               input bit enInDone, input int rstAt);
    logic [DATA_W-1:0] expWord;
    int seq [DEPTH];
    int errs;
    bit found;
    int firstAddr;
    int firstData;

    expWord = rev ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    errs = 0;
    found = 0;
    firstAddr = 0;
    firstData = 0;
    for (int k = 0; k < DEPTH; k++) begin
      seq[k] = dir ? (DEPTH - 1 - k) : k;
      if (mem[seq[k]] != expWord) begin
        errs++;
        if (!found) begin
          found = 1;
          firstAddr = seq[k];
          firstData = int'(mem[seq[k]]);
        end
      end
    end

    @(negedge clk);
    rev_in = rev;
    dir_in = dir;
    en_in  = 1'b1;
    @(negedge clk);
    en_in  = 1'b0;
    rev_in = ~rev;
    dir_in = ~dir;
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput($sformatf("addr_seq[%0d]", k), 32'(addr_out), 32'(seq[k]));
      checkOutput("r_en_in_sweep", 32'(r_en_out), 32'h1);
      checkOutput("busy_in_sweep", 32'(busy), 32'h1);
      checkOutput("chk_done_early", 32'(chk_done), 32'h0);
      if (rstAt == k + 1) begin
        rst = 1'b1;
        @(negedge clk);
        checkResetState("mid_sweep_reset");
        rst = 1'b0;
        return;
      end
      en_in = (enPulseAt == k + 1);
      @(negedge clk);
    end

    en_in = enInDone;
    checkOutput("chk_done_pulse", 32'(chk_done), 32'h1);
    checkOutput("r_en_at_done", 32'(r_en_out), 32'h0);
    checkOutput("addr_at_done", 32'(addr_out), 32'h0);
    checkOutput("busy_at_done", 32'(busy), 32'h1);
    checkOutput("fail", 32'(fail), 32'(found));
    checkOutput("fail_addr", 32'(fail_addr), 32'(firstAddr));
    checkOutput("fail_data", 32'(fail_data), 32'(firstData));
    checkOutput("err_cnt", 32'(err_cnt), 32'(errs));
    @(negedge clk);
    en_in = 1'b0;
    checkOutput("chk_done_cleared", 32'(chk_done), 32'h0);
    checkOutput("busy_after_done", 32'(busy), 32'h0);
    checkOutput("err_cnt_held", 32'(err_cnt), 32'(errs));
    checkOutput("fail_addr_held", 32'(fail_addr), 32'(firstAddr));
    @(negedge clk);
    checkOutput("no_restart_busy", 32'(busy), 32'h0);
    checkOutput("no_restart_r_en", 32'(r_en_out), 32'h0);
    checkOutput("no_second_done", 32'(chk_done), 32'h0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst    = 1'b1;
    en_in  = 1'b0;
    rev_in = 1'b0;
    dir_in = 1'b0;
    fillMem(4'h0, 0);
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    // Clean ascending all-0s
    applyStimulus(1'b0, 1'b0, -1, 1'b0, -1);

    // Single fault at 0x5A
    fillMem(4'h0, 0);
    mem[8'h5A] = 4'b0100;
    applyStimulus(1'b0, 1'b0, -1, 1'b0, -1);
    checkOutput("single.fail_addr", 32'(fail_addr), 32'h5A);
    checkOutput("single.fail_data", 32'(fail_data), 32'h4);
    checkOutput("single.err_cnt", 32'(err_cnt), 32'h1);

    // Descending, all-1s, two faults; 0xF0 is met first
    fillMem(4'hF, 0);
    mem[8'h10] = 4'b1110;
    mem[8'hF0] = 4'b0111;
    applyStimulus(1'b1, 1'b1, -1, 1'b0, -1);
    checkOutput("desc.fail_addr", 32'(fail_addr), 32'hF0);
    checkOutput("desc.fail_data", 32'(fail_data), 32'h7);
    checkOutput("desc.err_cnt", 32'(err_cnt), 32'h2);

    // Every word mismatches
    fillMem(4'h0, 0);
    applyStimulus(1'b1, 1'b0, -1, 1'b0, -1);
    checkOutput("allfail.err_cnt", 32'(err_cnt), 32'h100);
    checkOutput("allfail.fail_addr", 32'(fail_addr), 32'h0);
    checkOutput("allfail.fail_data", 32'(fail_data), 32'h0);

    // en_in pulsed mid-sweep and during DONE
    fillMem(4'h0, 3);
    applyStimulus(1'b0, 1'b0, 50, 1'b1, -1);

    // Reset mid-sweep, then a fresh clean sweep
    fillMem(4'hF, 10);
    applyStimulus(1'b1, 1'b0, -1, 1'b0, 100);
    fillMem(4'h0, 0);
    applyStimulus(1'b0, 1'b0, -1, 1'b0, -1);
    checkOutput("post_reset.err_cnt", 32'(err_cnt), 32'h0);

    // Reset and start on the same edge: reset wins
    @(negedge clk);
    rst   = 1'b1;
    en_in = 1'b1;
    @(negedge clk);
    checkOutput("rst_en.busy", 32'(busy), 32'h0);
    checkOutput("rst_en.r_en", 32'(r_en_out), 32'h0);
    rst   = 1'b0;
    en_in = 1'b0;
    @(negedge clk);
    checkOutput("rst_en.idle", 32'(busy), 32'h0);

    // Randomized sweeps
    for (int i = 0; i < 6; i++) begin
      logic r;
      logic d;
      r = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      fillMem({DATA_W{r}}, $urandom_range(0, 20));
      applyStimulus(r, d, -1, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
